// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the ALU.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             request; sampled only in IDLE or DONE
//   funct3            000 MUL 001 MULH 010 MULHSU 011 MULHU
//                     100 DIV 101 DIVU 110 REM 111 REMU
//   a, b              operands rs1 / rs2
//   rd_in             destination register index
//   busy              operation in progress (core stalls)
//   done              one-cycle result-valid pulse
//   result, rd_out    writeback data / index, held until next done
//   we_out            done && rd_out != 0
//
// Build option: define MULDIV_FAST_MUL_EN to compute all multiplies with a
// single combinational product (done one edge after start, no busy phase).
// Divides always iterate.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         funct3,
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  input  logic [RADDR_W-1:0] rd_in,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result,
  output logic [RADDR_W-1:0] rd_out,
  output logic               we_out
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]         op_q;
  logic [RADDR_W-1:0] rd_q;
  logic               neg_q;   // product / quotient negate
  logic               rneg_q;  // remainder negate (sign of dividend)
  logic [XLEN-1:0]    opb_q;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]  acc;     // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
  logic [CNT_W-1:0]   cnt;

  // ---- operand decode on the request side ----
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    if (funct3[2]) begin
      a_signed = !funct3[0];
      b_signed = !funct3[0];
    end else begin
      a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_signed = (funct3[1:0] == 2'b01);
    end
  end

  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign div_zero = funct3[2] && (b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  // Sign-extended 2*XLEN operands; the truncated product is exact mod 2^(2*XLEN).
  assign fast_prod = {{XLEN{a_neg}}, a} * {{XLEN{b_neg}}, b};
`endif

  always_comb begin
    special     = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : a;
`ifdef MULDIV_FAST_MUL_EN
    if (!funct3[2]) begin
      special     = 1'b1;
      special_res = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  assign accept = start && (state != S_BUSY);

  // ---- one iteration step ----
  logic [XLEN:0]      mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [2*XLEN-1:0]  acc_nxt, prod_s;
  logic [XLEN-1:0]    quo, rem, fin_res;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign div_diff = div_sh - {1'b0, opb_q};

  always_comb begin
    if (op_q[2])
      acc_nxt = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  // Final sign fix-up applied to the last iteration's output.
  assign prod_s = neg_q  ? -acc_nxt : acc_nxt;
  assign quo    = neg_q  ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem    = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    if (op_q[2])                fin_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00) fin_res = prod_s[XLEN-1:0];
    else                        fin_res = prod_s[2*XLEN-1:XLEN];
  end

  // ---- FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = special ? S_DONE : S_BUSY;
      S_BUSY: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE: begin
        if (start) state_nxt = special ? S_DONE : S_BUSY;
        else       state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      opb_q  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      op_q   <= funct3;
      rd_q   <= rd_in;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      opb_q  <= funct3[2] ? b_mag : a_mag;
      acc    <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      cnt    <= CNT_W'(XLEN);
      if (special) begin
        result <= special_res;
        rd_out <= rd_in;
      end
    end else if (state == S_BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        result <= fin_res;
        rd_out <= rd_q;
      end
    end
  end

  assign busy   = (state == S_BUSY);
  assign done   = (state == S_DONE);
  assign we_out = done && (rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, random
// operations against an arithmetic reference model, start-ignored-while-busy,
// asynchronous reset abort, and back-to-back starts from DONE.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done, we_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .we_out(we_out)
  );

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sp;
    logic [63:0] p;
    logic        ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin sp = sx * sy; p = sp; return p[63:32]; end
      3'd2: begin sp = sx * longint'({32'b0, y}); p = sp; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        sp = sx / sy; p = sp; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        sp = sx % sy; p = sp; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Edges from the start edge (counted as 1) to the first cycle with done high.
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    bit sp;
    sp = f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
    sp = sp || !f[2];
`endif
    return sp ? 1 : 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait (bounded) for done; operands are scrambled after
  // the start edge so any re-sampling would corrupt the result.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, output int lat, output int bcnt,
                        output logic [31:0] res, output logic [4:0] ro, output logic we);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y; rd_in = r;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; rd_in = 5'($urandom);
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result; ro = rd_out; we = we_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0; rd_in = '0;
    #12;
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (we_out !== 1'b0)   begin n_err++; $display("FAIL reset_we: got %b want 0", we_out); end
    n_vec++; if (result !== 32'h0)  begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_vec++; if (rd_out !== 5'h0)   begin n_err++; $display("FAIL reset_rd: got %h want 0", rd_out); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  df[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] dx[12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFEC, 32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100,
                            32'h80000000, 32'h80000000};
    logic [31:0] dy[12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] de[12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h1,
                            32'hFFFFFFFA, 32'hFFFFFFFE, 32'h5555554E, 32'hFFFFFFFF, 32'h64,
                            32'h80000000, 32'h0};
    int lat, bcnt; logic [31:0] res; logic [4:0] ro; logic we;
    for (int i = 0; i < 12; i++) begin
      run_op(df[i], dx[i], dy[i], 5'd5, lat, bcnt, res, ro, we);
      n_vec++; if (res !== de[i]) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, res, de[i]); end
      n_vec++; if (lat != exp_lat(df[i], dx[i], dy[i])) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(df[i], dx[i], dy[i])); end
      n_vec++; if (ro !== 5'd5) begin n_err++; $display("FAIL dir%0d_rd: got %0d want 5", i, ro); end
      n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL dir%0d_we: got %b want 1", i, we); end
      if (i == 0) begin
        n_vec++; if (bcnt != ((exp_lat(df[i], dx[i], dy[i]) == 1) ? 0 : 32)) begin n_err++; $display("FAIL dir0_busy_cycles: got %0d want %0d", bcnt, (exp_lat(df[i], dx[i], dy[i]) == 1) ? 0 : 32); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0 || we_out !== 1'b0) begin n_err++; $display("FAIL dir0_pulse_width: got done=%b we=%b want 0 0", done, we_out); end
        n_vec++; if (result !== de[0]) begin n_err++; $display("FAIL dir0_hold: got %h want %h", result, de[0]); end
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt; logic [31:0] res, x, y, e; logic [4:0] ro, r; logic we; logic [2:0] f;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7)); x = rnd_operand(); y = rnd_operand(); r = 5'($urandom);
      e = model(f, x, y);
      run_op(f, x, y, r, lat, bcnt, res, ro, we);
      n_vec++; if (res !== e) begin n_err++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h want %h", i, f, x, y, res, e); end
      n_vec++; if (lat != exp_lat(f, x, y)) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat(f, x, y)); end
      n_vec++; if (bcnt != lat - 1) begin n_err++; $display("FAIL rnd%0d_busy_cycles: got %0d want %0d", i, bcnt, lat - 1); end
      n_vec++; if (ro !== r || we !== (r != 0)) begin n_err++; $display("FAIL rnd%0d_wb: got rd=%0d we=%b want rd=%0d we=%b", i, ro, we, r, r != 0); end
    end
  endtask

  task automatic test_ignore_and_abort();
    int lat, seen;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd1000; b = 32'd7; rd_in = 5'd4;
    @(posedge clk); #1; start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 4) begin
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; a = 32'd5; b = 32'd1; rd_in = 5'd9;
      end
      @(posedge clk); #1; start = 1'b0;
      lat++;
    end
    n_vec++; if (result !== 32'd142) begin n_err++; $display("FAIL ignore_result: got %0d want 142", result); end
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    n_vec++; if (rd_out !== 5'd4) begin n_err++; $display("FAIL ignore_rd: got %0d want 4", rd_out); end

    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; a = 32'd1000; b = 32'd7; rd_in = 5'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || we_out !== 1'b0) begin n_err++; $display("FAIL abort_flags: got busy=%b done=%b we=%b want 0 0 0", busy, done, we_out); end
    n_vec++; if (result !== 32'h0 || rd_out !== 5'h0) begin n_err++; $display("FAIL abort_regs: got result=%h rd=%0d want 0 0", result, rd_out); end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic [31:0] res; logic [4:0] ro; logic we;
    run_op(3'd0, 32'd3, 32'd4, 5'd0, lat, bcnt, res, ro, we);
    n_vec++; if (res !== 32'd12) begin n_err++; $display("FAIL b2b_mul_result: got %0d want 12", res); end
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL b2b_mul_we: got %b want 0", we); end
    // Still in DONE: launch a divide on the same edge the pulse ends.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1; start = 1'b0;
    n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done); end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    n_vec++; if (result !== 32'd14 || lat != 33) begin n_err++; $display("FAIL b2b_div: got %0d lat %0d want 14 lat 33", result, lat); end
    // Restart from DONE into a special case: done stays high with new data.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd7; a = 32'd55; b = 32'd0; rd_in = 5'd2;
    @(posedge clk); #1; start = 1'b0;
    n_vec++; if (done !== 1'b1 || result !== 32'd55 || rd_out !== 5'd2) begin n_err++; $display("FAIL b2b_special: got done=%b result=%0d rd=%0d want 1 55 2", done, result, rd_out); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0 || result !== 32'd55) begin n_err++; $display("FAIL b2b_idle_hold: got done=%b result=%0d want 0 55", done, result); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_and_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
